// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared opcodes, timing constants and state encoding for the SPI flash loader (SPI_FLASH_LOADER_FAST_READ_EN selects the command set)
package spi_flash_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] DUMMY_BYTE   = 8'hFF;

    // Engine request window length and chip-select framing, in clocks
    localparam int REQ_HOLD        = 2;
    localparam int CS_SETUP_CYCLES = 2;
    localparam int CS_HOLD_CYCLES  = 2;

`ifdef SPI_FLASH_LOADER_FAST_READ_EN
    localparam logic [7:0] OP_CMD = OP_FAST_READ;
`else
    localparam logic [7:0] OP_CMD = OP_READ;
`endif

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_CMD,
        ST_ADDR2,
        ST_ADDR1,
        ST_ADDR0,
`ifdef SPI_FLASH_LOADER_FAST_READ_EN
        ST_DUMMY,
`endif
        ST_PRIME,
        ST_DATA,
        ST_CS_HOLD
    } state_t;

endpackage

// File: rtl/spi_xfer_pacer.sv
// rtl/spi_xfer_pacer.sv - issues 2-cycle engine requests, flags the sample cycle and enforces request spacing
module spi_xfer_pacer
    import spi_flash_pkg::*;
#(
    parameter int XFER_CYCLES = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic kick,
    input  logic kick_recv,
    output logic ready,
    output logic send,
    output logic recv,
    output logic sample
);

    localparam int CNT_W = $clog2(XFER_CYCLES + 1);

    logic [CNT_W-1:0] gap_cnt;
    logic [1:0]       hold_left;

    // A new request may start once the spacing counter has drained
    assign ready = (gap_cnt == '0);

    // Request window, sample strobe (last high cycle of a recv) and spacing counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt   <= '0;
            hold_left <= '0;
            send      <= 1'b0;
            recv      <= 1'b0;
            sample    <= 1'b0;
        end else begin
            sample <= 1'b0;
            if (kick && ready) begin
                gap_cnt   <= CNT_W'(XFER_CYCLES - 1);
                hold_left <= 2'(REQ_HOLD - 1);
                send      <= !kick_recv;
                recv      <= kick_recv;
            end else begin
                if (gap_cnt != '0) begin
                    gap_cnt <= gap_cnt - CNT_W'(1);
                end
                if (hold_left != 2'd0) begin
                    hold_left <= hold_left - 2'd1;
                    sample    <= recv && (hold_left == 2'd1);
                end else begin
                    send <= 1'b0;
                    recv <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/spi_flash_loader.sv
// rtl/spi_flash_loader.sv - streams a block of SPI flash into on-chip memory (SPI_FLASH_LOADER_FAST_READ_EN adds FAST_READ + dummy byte)
module spi_flash_loader
    import spi_flash_pkg::*;
#(
    parameter int LEN_W       = 14,
    parameter int XFER_CYCLES = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [23:0]      base_addr,
    input  logic [LEN_W-1:0] length,
    input  logic [LEN_W-1:0] mem_base,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             flash_cs_n,
    output logic             spi_send,
    output logic             spi_recv,
    output logic [7:0]       spi_wdata,
    input  logic [7:0]       spi_rdata,
    output logic             mem_we,
    output logic [LEN_W-1:0] mem_addr,
    output logic [7:0]       mem_wdata
);

    state_t           state;
    logic [23:0]      flash_addr;
    logic [LEN_W-1:0] remaining;
    logic [1:0]       cs_cnt;
    logic             discard;
    logic             pacer_ready;
    logic             pacer_sample;
    logic             kick;
    logic             kick_recv;
    logic [7:0]       tx_byte;
    logic             abort_go;

    spi_xfer_pacer #(
        .XFER_CYCLES(XFER_CYCLES)
    ) u_pacer (
        .clk      (clk),
        .rst_n    (rst_n),
        .kick     (kick),
        .kick_recv(kick_recv),
        .ready    (pacer_ready),
        .send     (spi_send),
        .recv     (spi_recv),
        .sample   (pacer_sample)
    );

    // Abort is honoured from every active state except the closing one
    assign abort_go = abort && (state != ST_IDLE) && (state != ST_CS_HOLD);

    // Decide whether a request starts this cycle and which byte goes out
    always_comb begin
        kick      = 1'b0;
        kick_recv = 1'b0;
        tx_byte   = spi_wdata;
        if (pacer_ready && !abort) begin
            case (state)
                ST_CMD:   begin kick = 1'b1; tx_byte = OP_CMD;            end
                ST_ADDR2: begin kick = 1'b1; tx_byte = flash_addr[23:16]; end
                ST_ADDR1: begin kick = 1'b1; tx_byte = flash_addr[15:8];  end
                ST_ADDR0: begin kick = 1'b1; tx_byte = flash_addr[7:0];   end
`ifdef SPI_FLASH_LOADER_FAST_READ_EN
                ST_DUMMY: begin kick = 1'b1; tx_byte = DUMMY_BYTE;        end
`endif
                ST_PRIME, ST_DATA: begin kick = 1'b1; kick_recv = 1'b1;  end
                default: ;
            endcase
        end
    end

    // Load sequencer: chip-select framing, header, data capture and memory writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            flash_addr <= '0;
            remaining  <= '0;
            cs_cnt     <= '0;
            discard    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            flash_cs_n <= 1'b1;
            spi_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            done   <= 1'b0;
            mem_we <= 1'b0;
            if (mem_we) begin
                mem_addr <= mem_addr + LEN_W'(1);
            end
            if (kick) begin
                spi_wdata <= tx_byte;
            end
            if (abort_go) begin
                state <= ST_CS_HOLD;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            flash_addr <= base_addr;
                            remaining  <= length;
                            mem_addr   <= mem_base;
                            if (length == '0) begin
                                done <= 1'b1;
                            end else begin
                                busy       <= 1'b1;
                                flash_cs_n <= 1'b0;
                                cs_cnt     <= 2'(CS_SETUP_CYCLES - 1);
                                state      <= ST_CS_SETUP;
                            end
                        end
                    end
                    ST_CS_SETUP: begin
                        if (cs_cnt != 2'd0) cs_cnt <= cs_cnt - 2'd1;
                        else                state  <= ST_CMD;
                    end
                    ST_CMD:   if (kick) state <= ST_ADDR2;
                    ST_ADDR2: if (kick) state <= ST_ADDR1;
                    ST_ADDR1: if (kick) state <= ST_ADDR0;
`ifdef SPI_FLASH_LOADER_FAST_READ_EN
                    ST_ADDR0: if (kick) state <= ST_DUMMY;
                    ST_DUMMY: if (kick) state <= ST_PRIME;
`else
                    ST_ADDR0: if (kick) state <= ST_PRIME;
`endif
                    ST_PRIME: begin
                        if (kick) begin
                            discard <= 1'b1;
                            state   <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (pacer_sample) begin
                            if (discard) begin
                                discard <= 1'b0;
                            end else begin
                                mem_we    <= 1'b1;
                                mem_wdata <= spi_rdata;
                                remaining <= remaining - LEN_W'(1);
                                if (remaining == LEN_W'(1)) state <= ST_CS_HOLD;
                            end
                        end
                    end
                    ST_CS_HOLD: begin
                        if (!flash_cs_n) begin
                            if (pacer_ready) begin
                                flash_cs_n <= 1'b1;
                                cs_cnt     <= 2'(CS_HOLD_CYCLES - 1);
                            end
                        end else if (cs_cnt != 2'd0) begin
                            cs_cnt <= cs_cnt - 2'd1;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
